// File: rtl/voice_scheduler.sv
// voice_scheduler: derives the audio sample tick from clk and, on every
// tick, walks each voice through the shared oscillator/gain datapath using a
// req/ack handshake. It owns the per-voice phase accumulators and sums the
// returned voice samples into one mixed output sample per tick.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | waiting for the sample tick; mix is cleared when a tick arrives
// S_WAIT | dp_req high for voice dp_voice; each ack accumulates and advances
// S_DONE | sample_valid pulse carrying the scaled mix, then back to S_IDLE
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int TICK_DIV   = 272,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_W   = 16,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [VW-1:0]              cfg_addr,
    input  logic [PHASE_W-1:0]         cfg_data,
    output logic                       dp_req,
    output logic [VW-1:0]              dp_voice,
    output logic [PHASE_W-1:0]         dp_phase,
    input  logic                       dp_ack,
    input  logic signed [SAMPLE_W-1:0] dp_sample,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int MIX_W = SAMPLE_W + VW;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [VW-1:0]    LAST_V    = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           tick_cnt;
    logic                       tick;
    logic [PHASE_W-1:0]         phase [NUM_VOICES];
    logic [PHASE_W-1:0]         inc   [NUM_VOICES];
    logic signed [MIX_W-1:0]    mix;
    logic signed [MIX_W-1:0]    samp_ext;
    logic signed [MIX_W-1:0]    mix_next;
    logic signed [MIX_W-1:0]    mix_scaled;
    logic [VW-1:0]              next_voice;

    assign tick       = (tick_cnt == TICK_LAST);
    assign samp_ext   = {{VW{dp_sample[SAMPLE_W-1]}}, dp_sample};
    assign mix_next   = mix + samp_ext;
    // Mix cannot exceed NUM_VOICES full-scale samples, so after dividing by
    // NUM_VOICES the top VW bits are pure sign and can be dropped.
    assign mix_scaled = mix_next >>> VW;
    assign next_voice = dp_voice + 1'b1;
    assign busy       = (state != S_IDLE);

    // Sample-tick divider: counts 0..TICK_DIV-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Phase-increment registers, written at any time without stalling the scheduler.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                inc[i] <= '0;
            end
        end else if (cfg_we) begin
            inc[cfg_addr] <= cfg_data;
        end
    end

    // Scheduler FSM: handshake, phase accumulation, mixing and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dp_req       <= 1'b0;
            dp_voice     <= '0;
            dp_phase     <= '0;
            mix          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        mix      <= '0;
                        dp_voice <= '0;
                        dp_phase <= phase[0];
                        dp_req   <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dp_ack) begin
                        mix             <= mix_next;
                        // inc is read before any same-cycle cfg write lands.
                        phase[dp_voice] <= phase[dp_voice] + inc[dp_voice];
                        if (dp_voice == LAST_V) begin
                            dp_req       <= 1'b0;
                            sample_out   <= mix_scaled[SAMPLE_W-1:0];
                            sample_valid <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            dp_voice <= next_voice;
                            dp_phase <= phase[next_voice];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    dp_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: a 272-cycle-tick instance for the main
// scenarios and an 8-cycle-tick instance for overrun behaviour.
module tb_voice_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // main instance (TICK_DIV = 272)
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [15:0]        cfg_data = '0;
    logic               dp_req;
    logic [1:0]         dp_voice;
    logic [15:0]        dp_phase;
    logic               dp_ack;
    logic signed [15:0] dp_sample;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               busy;
    logic               overrun;

    // small-divider instance (TICK_DIV = 8)
    logic               rst8 = 1'b1;
    logic               cfg_we8 = 1'b0;
    logic [1:0]         cfg_addr8 = '0;
    logic [15:0]        cfg_data8 = '0;
    logic               dp_req8;
    logic [1:0]         dp_voice8;
    logic [15:0]        dp_phase8;
    logic               dp_ack8;
    logic signed [15:0] dp_sample8;
    logic signed [15:0] sample_out8;
    logic               sample_valid8;
    logic               busy8;
    logic               overrun8;

    voice_scheduler #(.NUM_VOICES(4), .TICK_DIV(272), .PHASE_W(16), .SAMPLE_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .dp_req(dp_req), .dp_voice(dp_voice), .dp_phase(dp_phase), .dp_ack(dp_ack),
        .dp_sample(dp_sample), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .overrun(overrun)
    );

    voice_scheduler #(.NUM_VOICES(4), .TICK_DIV(8), .PHASE_W(16), .SAMPLE_W(16)) dut8 (
        .clk(clk), .rst(rst8), .cfg_we(cfg_we8), .cfg_addr(cfg_addr8), .cfg_data(cfg_data8),
        .dp_req(dp_req8), .dp_voice(dp_voice8), .dp_phase(dp_phase8), .dp_ack(dp_ack8),
        .dp_sample(dp_sample8), .sample_out(sample_out8), .sample_valid(sample_valid8),
        .busy(busy8), .overrun(overrun8)
    );

    // datapath model: delay 0 = ack tied high, delay d = ack on the d-th request cycle
    int delay = 0;
    logic signed [15:0] samp_tab [4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};

    initial begin
        int sc;
        sc = 0;
        dp_ack = 1'b0;
        dp_sample = '0;
        forever begin
            @(negedge clk);
            dp_sample = samp_tab[dp_voice];
            if (delay == 0) begin
                dp_ack = 1'b1;
            end else if (dp_req) begin
                if (sc == delay - 1) begin
                    dp_ack = 1'b1;
                    sc = 0;
                end else begin
                    dp_ack = 1'b0;
                    sc++;
                end
            end else begin
                dp_ack = 1'b0;
                sc = 0;
            end
        end
    end

    // datapath model for the small-divider instance: ack on the 3rd request cycle
    initial begin
        int sc;
        sc = 0;
        dp_ack8 = 1'b0;
        dp_sample8 = '0;
        forever begin
            @(negedge clk);
            if (dp_req8) begin
                if (sc == 2) begin
                    dp_ack8 = 1'b1;
                    sc = 0;
                end else begin
                    dp_ack8 = 1'b0;
                    sc++;
                end
            end else begin
                dp_ack8 = 1'b0;
                sc = 0;
            end
        end
    end

    logic [15:0] inc_vals [4] = '{16'h0100, 16'h0200, 16'h8000, 16'hFFFF};

    logic [15:0] ph_exp [3][4] = '{
        '{16'h0000, 16'h0000, 16'h0000, 16'h0000},
        '{16'h0100, 16'h0200, 16'h8000, 16'hFFFF},
        '{16'h0200, 16'h0400, 16'h0000, 16'hFFFE}
    };

    logic signed [15:0] mix_in [3][4] = '{
        '{16'sd32767, 16'sd32767, -16'sd32768, 16'sd4},
        '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768},
        '{-16'sd1, -16'sd1, -16'sd1, -16'sd2}
    };
    logic signed [15:0] mix_out [3] = '{16'sd8192, -16'sd32768, -16'sd2};
    logic [15:0] ph_mix [3][4] = '{
        '{16'h0300, 16'h0600, 16'h8000, 16'hFFFD},
        '{16'h0400, 16'h0800, 16'h0000, 16'hFFFC},
        '{16'h0500, 16'h0A00, 16'h8000, 16'hFFFB}
    };

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // advance until dp_req is seen high; n = cycles advanced
    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (dp_req !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (dp_req !== 1'b1) begin
            failures++;
            $display("FAIL wait_req timeout got dp_req=%b after %0d cycles", dp_req, n);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        delay = 0;
        for (int v = 0; v < 4; v++) samp_tab[v] = '0;
        step(3);
        rst = 1'b0;
        checks++;
        if ({dp_req, dp_voice, dp_phase, sample_out, sample_valid, busy, overrun} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b voice=%0d phase=%h out=%h valid=%b busy=%b ovr=%b exp all zero",
                     dp_req, dp_voice, dp_phase, sample_out, sample_valid, busy, overrun);
        end
        for (int t = 0; t < 2; t++) begin
            wait_req(400, n);
            // first request 272 cycles after reset; later ones 272 after the previous tick
            checks++;
            if (n !== ((t == 0) ? 272 : 267)) begin
                failures++;
                $display("FAIL tick_period got=%0d exp=%0d", n, (t == 0) ? 272 : 267);
            end
            for (int v = 0; v < 4; v++) begin
                checks++;
                if (dp_voice !== 2'(v) || dp_phase !== 16'h0000) begin
                    failures++;
                    $display("FAIL idle_phase got voice=%0d phase=%h exp voice=%0d phase=0000", dp_voice, dp_phase, v);
                end
                step(1);
            end
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== 16'sd0 || busy !== 1'b1 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL idle_sample got valid=%b out=%h busy=%b ovr=%b exp 1 0000 1 0",
                         sample_valid, sample_out, busy, overrun);
            end
            step(1);
            checks++;
            if (sample_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL back_to_idle got valid=%b busy=%b exp 0 0", sample_valid, busy);
            end
        end
    endtask

    task automatic test_phase_accum();
        int n;
        for (int v = 0; v < 4; v++) begin
            cfg_we = 1'b1;
            cfg_addr = 2'(v);
            cfg_data = inc_vals[v];
            step(1);
        end
        cfg_we = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wait_req(400, n);
            for (int v = 0; v < 4; v++) begin
                checks++;
                if (dp_voice !== 2'(v) || dp_phase !== ph_exp[t][v]) begin
                    failures++;
                    $display("FAIL phase_accum tick%0d got voice=%0d phase=%h exp voice=%0d phase=%h",
                             t, dp_voice, dp_phase, v, ph_exp[t][v]);
                end
                step(1);
            end
            step(1);
        end
    endtask

    task automatic test_mix();
        int n;
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 4; v++) samp_tab[v] = mix_in[r][v];
            wait_req(400, n);
            for (int v = 0; v < 4; v++) begin
                checks++;
                if (dp_voice !== 2'(v) || dp_phase !== ph_mix[r][v]) begin
                    failures++;
                    $display("FAIL mix_phase row%0d got voice=%0d phase=%h exp voice=%0d phase=%h",
                             r, dp_voice, dp_phase, v, ph_mix[r][v]);
                end
                step(1);
            end
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== mix_out[r]) begin
                failures++;
                $display("FAIL mix_result row%0d got valid=%b out=%0d exp valid=1 out=%0d",
                         r, sample_valid, sample_out, mix_out[r]);
            end
            step(1);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [15:0] ph [4];
        ph = '{16'h0600, 16'h0C00, 16'h0000, 16'hFFFA};
        samp_tab = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
        delay = 5;
        wait_req(400, n);
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (dp_req !== 1'b1 || dp_voice !== 2'(v) || dp_phase !== ph[v] || sample_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_stable v%0d c%0d got req=%b voice=%0d phase=%h valid=%b exp 1 %0d %h 0",
                             v, c, dp_req, dp_voice, dp_phase, sample_valid, v, ph[v]);
                end
                step(1);
            end
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'sd250 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL stall_result got valid=%b out=%0d ovr=%b exp 1 250 0", sample_valid, sample_out, overrun);
        end
        step(1);
        delay = 0;
    endtask

    task automatic test_cfg_collision();
        int n;
        logic [15:0] ph9 [4];
        logic [15:0] ph10 [4];
        ph9  = '{16'h0800, 16'h1000, 16'h0000, 16'hFFF8};
        ph10 = '{16'h0900, 16'h1010, 16'h8000, 16'hFFF9};
        samp_tab = '{16'sd8, 16'sd8, 16'sd8, 16'sd8};
        // tick observing 7*inc; rewrite voice 1's inc in its own completion cycle
        wait_req(400, n);
        checks++;
        if (dp_phase !== 16'h0700) begin
            failures++;
            $display("FAIL collide_v0 got=%h exp=0700", dp_phase);
        end
        step(1);
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = 16'h0010;
        checks++;
        if (dp_voice !== 2'd1 || dp_phase !== 16'h0E00) begin
            failures++;
            $display("FAIL collide_v1 got voice=%0d phase=%h exp 1 0E00", dp_voice, dp_phase);
        end
        step(1);
        cfg_we = 1'b0;
        step(3);
        // next tick: write voice 3's inc while voice 0 is being processed
        wait_req(400, n);
        cfg_we = 1'b1;
        cfg_addr = 2'd3;
        cfg_data = 16'h0001;
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dp_voice !== 2'(v) || dp_phase !== ph9[v]) begin
                failures++;
                $display("FAIL collide_next v%0d got voice=%0d phase=%h exp %h", v, dp_voice, dp_phase, ph9[v]);
            end
            step(1);
            cfg_we = 1'b0;
        end
        step(1);
        wait_req(400, n);
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dp_voice !== 2'(v) || dp_phase !== ph10[v]) begin
                failures++;
                $display("FAIL collide_after v%0d got voice=%0d phase=%h exp %h", v, dp_voice, dp_phase, ph10[v]);
            end
            step(1);
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'sd8) begin
            failures++;
            $display("FAIL collide_sample got valid=%b out=%0d exp 1 8", sample_valid, sample_out);
        end
        step(1);
    endtask

    task automatic test_overrun();
        int svc;
        int bad_ovr;
        logic exp_sv;
        svc = 0;
        bad_ovr = 0;
        rst8 = 1'b1;
        step(3);
        rst8 = 1'b0;
        // accepted ticks at k=7,23,39,...; the ticks at k=15,31,... land in WAIT
        for (int k = 0; k < 100; k++) begin
            exp_sv = (k >= 20) && (((k - 20) % 16) == 0);
            checks++;
            if (sample_valid8 !== exp_sv) begin
                failures++;
                $display("FAIL overrun_valid k=%0d got=%b exp=%b", k, sample_valid8, exp_sv);
            end
            if (sample_valid8 === 1'b1) svc++;
            if (k == 15) begin
                checks++;
                if (overrun8 !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_early got=%b exp=0", overrun8);
                end
            end
            if (k == 16) begin
                checks++;
                if (overrun8 !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_rise got=%b exp=1", overrun8);
                end
            end
            if (k > 16 && overrun8 !== 1'b1) bad_ovr++;
            step(1);
        end
        checks++;
        if (bad_ovr !== 0) begin
            failures++;
            $display("FAIL overrun_sticky got %0d low cycles exp 0", bad_ovr);
        end
        checks++;
        if (svc !== 5) begin
            failures++;
            $display("FAIL overrun_count got=%0d exp=5", svc);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int svc;
        samp_tab = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
        delay = 5;
        wait_req(400, n);
        step(10);
        checks++;
        if (dp_voice !== 2'd2 || dp_req !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre got voice=%0d req=%b exp 2 1", dp_voice, dp_req);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        delay = 0;
        checks++;
        if ({dp_req, dp_voice, dp_phase, sample_out, sample_valid, busy, overrun} !== 38'd0) begin
            failures++;
            $display("FAIL midrst_outputs got req=%b voice=%0d phase=%h out=%h valid=%b busy=%b ovr=%b exp all zero",
                     dp_req, dp_voice, dp_phase, sample_out, sample_valid, busy, overrun);
        end
        n = 0;
        svc = 0;
        while (dp_req !== 1'b1 && n < 400) begin
            if (sample_valid === 1'b1) svc++;
            step(1);
            n++;
        end
        checks++;
        if (n !== 272 || svc !== 0) begin
            failures++;
            $display("FAIL midrst_rerun got latency=%0d valids=%0d exp 272 0", n, svc);
        end
        for (int v = 0; v < 4; v++) begin
            checks++;
            if (dp_voice !== 2'(v) || dp_phase !== 16'h0000) begin
                failures++;
                $display("FAIL midrst_phase got voice=%0d phase=%h exp voice=%0d phase=0000", dp_voice, dp_phase, v);
            end
            step(1);
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'sd0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL midrst_sample got valid=%b out=%0d ovr=%b exp 1 0 0", sample_valid, sample_out, overrun);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_phase_accum();
        test_mix();
        test_stall();
        test_cfg_collision();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
